// File: rtl/mul_booth_if.sv
// Handshake and result bus between the CPU control unit and the sequential
// Booth multiplier.
interface mul_booth_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, a, b, input busy, done, hi, lo);
    modport slave  (input start, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mul_booth_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock through one adder.
// Optional MUL_EARLY_TERM_EN finishes as soon as the remaining multiplier digits are all zero.
module mul_booth_seq #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        clr,
    mul_booth_if.slave bus
);
    localparam int PW = 2 * WIDTH + 3;
    localparam int CW = $clog2(WIDTH / 2);
    localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   p_reg;
    logic [WIDTH+1:0] m_reg;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH+1:0] digit_val;
    logic [WIDTH+1:0] acc_sum;
    logic [PW-1:0]   p_added;
    logic [PW-1:0]   p_step;
    logic            early_term;
    logic            last_step;
    logic            accept;
    logic            busy_dec;
    logic            done_dec;
`ifdef MUL_EARLY_TERM_EN
    logic            ident;
    int              shamt;
`endif

    assign accept    = bus.start && (state != RUN);
    assign last_step = (count == LAST) || early_term;

    // P is {acc, multiplier remainder, q}; the low three bits select the Booth digit.
    always_comb begin
        case (p_reg[2:0])
            3'b001, 3'b010: digit_val = m_reg;
            3'b011:         digit_val = m_reg << 1;
            3'b100:         digit_val = -(m_reg << 1);
            3'b101, 3'b110: digit_val = -m_reg;
            default:        digit_val = '0;
        endcase
        acc_sum = p_reg[PW-1:WIDTH+1] + digit_val;
        p_added = {acc_sum, p_reg[WIDTH:0]};
`ifdef MUL_EARLY_TERM_EN
        ident = 1'b1;
        for (int i = 3; i <= WIDTH; i++) begin
            if ((i <= WIDTH - 2 * int'(count)) && (p_reg[i] != p_reg[2])) begin
                ident = 1'b0;
            end
        end
        shamt = WIDTH - 2 * int'(count);
        if (ident) begin
            p_step = $signed(p_added) >>> shamt;
        end else begin
            p_step = $signed(p_added) >>> 2;
        end
        early_term = ident;
`else
        p_step     = $signed(p_added) >>> 2;
        early_term = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy_dec   = 1'b0;
        done_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) next_state = RUN;
            end
            RUN: begin
                busy_dec = 1'b1;
                if (last_step) next_state = DONE;
            end
            DONE: begin
                done_dec   = 1'b1;
                next_state = bus.start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // hi/lo only change on the edge entering DONE, so a back-to-back start keeps the old result.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            p_reg  <= '0;
            m_reg  <= '0;
            count  <= '0;
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (accept) begin
            m_reg <= {{2{bus.a[WIDTH-1]}}, bus.a};
            p_reg <= {{(WIDTH + 2){1'b0}}, bus.b, 1'b0};
            count <= '0;
        end else if (state == RUN) begin
            p_reg <= p_step;
            count <= count + 1'b1;
            if (last_step) begin
                hi_reg <= p_step[2*WIDTH:WIDTH+1];
                lo_reg <= p_step[WIDTH:1];
            end
        end
    end

    assign bus.busy = busy_dec;
    assign bus.done = done_dec;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_mul_booth_seq.sv
// Self-checking bench for mul_booth_seq: directed corner cases, back-to-back,
// mid-run reset and randomized operands against a plain-arithmetic reference.
module tb_mul_booth_seq;
    logic clk;
    logic clr;
    int   check_count;
    int   pass_count;

    mul_booth_if #(.WIDTH(32)) bus ();

    mul_booth_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] ref_product(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        return 64'(sx * sy);
    endfunction

    // Number of RUN cycles the multiplier needs for multiplier operand y.
    function automatic int ref_cycles(input logic [31:0] y);
`ifdef MUL_EARLY_TERM_EN
        int sy;
        int rest;
        sy = signed'(y);
        for (int c = 0; c < 16; c++) begin
            rest = sy >>> (2 * c + 1);
            if (rest == 0 || rest == -1) return c + 1;
        end
        return 16;
`else
        return (y === y) ? 16 : 16;
`endif
    endfunction

    // Waits from the first cycle after the accepting edge until done, counting busy cycles.
    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (!bus.done && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        check_output({tag, " done"}, 64'(bus.done), 64'd1);
    endtask

    task automatic apply_stimulus(input logic [31:0] op_a, input logic [31:0] op_b, input string tag);
        int          cycles;
        logic [63:0] expect_prod;
        expect_prod = ref_product(op_a, op_b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = op_a;
        bus.b     = op_b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        wait_done(tag, cycles);
        check_output({tag, " latency"}, 64'(cycles), 64'(ref_cycles(op_b)));
        check_output({tag, " product"}, {bus.hi, bus.lo}, expect_prod);
        @(negedge clk);
        check_output({tag, " done pulse"}, 64'(bus.done), 64'd0);
        check_output({tag, " hold"}, {bus.hi, bus.lo}, expect_prod);
    endtask

    initial begin
        int          cycles;
        int          done_seen;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] a2;
        logic [31:0] b2;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sb;

        check_count = 0;
        pass_count  = 0;
        clr         = 1'b0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        repeat (3) @(negedge clk);
        check_output("reset busy", 64'(bus.busy), 64'd0);
        check_output("reset done", 64'(bus.done), 64'd0);
        check_output("reset hi", 64'(bus.hi), 64'd0);
        check_output("reset lo", 64'(bus.lo), 64'd0);
        clr = 1'b1;
        @(negedge clk);

        apply_stimulus(32'd3, 32'd5, "3x5");
        apply_stimulus(32'hFFFFFFF9, 32'd3, "-7x3");
        apply_stimulus(32'hFFFFFFFF, 32'hFFFFFFFF, "-1x-1");
        apply_stimulus(32'h80000000, 32'h80000000, "minxmin");
        apply_stimulus(32'h7FFFFFFF, 32'h7FFFFFFF, "maxxmax");
        apply_stimulus(32'h12345678, 32'd0, "b zero");
        apply_stimulus(32'h12345678, 32'd1, "b one");
        apply_stimulus(32'h0000ABCD, 32'h00010000, "b bit16");
        apply_stimulus(32'h80000000, 32'h7FFFFFFF, "minxmax");

        // start held high: operands scrambled during RUN, second op starts from DONE.
        a1 = 32'hFEDC1234;
        b1 = 32'h13572468;
        a2 = 32'h00000ABC;
        b2 = 32'hFFFF0001;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a1;
        bus.b     = b1;
        @(negedge clk);
        cycles = 0;
        while (!bus.done && cycles < 40) begin
            bus.a = $urandom;
            bus.b = $urandom;
            cycles++;
            @(negedge clk);
        end
        check_output("b2b first done", 64'(bus.done), 64'd1);
        check_output("b2b first latency", 64'(cycles), 64'(ref_cycles(b1)));
        check_output("b2b first product", {bus.hi, bus.lo}, ref_product(a1, b1));
        bus.a = a2;
        bus.b = b2;
        @(negedge clk);
        bus.start = 1'b0;
        check_output("b2b no gap busy", 64'(bus.busy), 64'd1);
        check_output("b2b old result held", {bus.hi, bus.lo}, ref_product(a1, b1));
        wait_done("b2b second", cycles);
        check_output("b2b second latency", 64'(cycles), 64'(ref_cycles(b2)));
        check_output("b2b second product", {bus.hi, bus.lo}, ref_product(a2, b2));
        @(negedge clk);

        // Reset asserted after seven RUN cycles aborts the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h0BADF00D;
        bus.b     = 32'h55555555;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        clr = 1'b0;
        #1;
        check_output("abort busy", 64'(bus.busy), 64'd0);
        check_output("abort done", 64'(bus.done), 64'd0);
        check_output("abort hi", 64'(bus.hi), 64'd0);
        check_output("abort lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        clr       = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check_output("abort no done", 64'(done_seen), 64'd0);
        apply_stimulus(32'd2, 32'd2, "after abort");

        for (int n = 0; n < 2000; n++) begin
            ra = $urandom;
            sb = int'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 32'(sb >>> $urandom_range(0, 31));
                1:       rb = 32'(sb <<< $urandom_range(0, 31));
                default: rb = 32'(sb);
            endcase
            apply_stimulus(ra, rb, "random");
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
